lbl2rgb: RTL

Streaming back-converter from the label/intensity domain to displayable RGB, i.e. the output-side counterpart of the RGB-to-intensity front end. It takes one label (or intensity) per cycle under a valid/ready handshake and emits a 24-bit RGB pixel through a 2-stage pipeline with full backpressure. It also tracks the largest label seen in each frame for the host/debug readout.

---
 rtl/lbl2rgb_pkg.sv | 21 ++
 rtl/lbl2rgb_hash.sv | 29 ++
 rtl/lbl2rgb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lbl2rgb_pkg.sv
// lbl2rgb_pkg
// Shared constants for the label-to-RGB back-converter: channel width,
// default label width, channel saturation values and the per-pixel mode
// encodings carried down the pipeline.
package lbl2rgb_pkg;

  localparam int WORD_SIZE     = 8;
  localparam int DEF_LBL_WIDTH = 16;

  localparam logic [WORD_SIZE-1:0] MAX = '1;
  localparam logic [WORD_SIZE-1:0] MIN = '0;

  // Encoding 3 is not a distinct mode; it renders exactly like MODE_HASH.
  typedef enum logic [1:0] {
    MODE_HASH = 2'd0,
    MODE_GREY = 2'd1,
    MODE_BIN  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

endpackage

// File: rtl/lbl2rgb_hash.sv
// lbl2rgb_hash
// Combinational label hash: multiplies the label by three odd constants and
// keeps the low byte of each product, giving well-spread pseudo-colours for
// neighbouring label values.
// Ports:
//   i_lbl  in  WORD_SIZE  low byte of the label (higher bits cannot affect a
//                         product taken mod 2^WORD_SIZE)
//   o_p_r  out WORD_SIZE  (lbl * 37)  mod 2^WORD_SIZE
//   o_p_g  out WORD_SIZE  (lbl * 101) mod 2^WORD_SIZE
//   o_p_b  out WORD_SIZE  (lbl * 173) mod 2^WORD_SIZE
module lbl2rgb_hash
  import lbl2rgb_pkg::*;
(
  input  logic [WORD_SIZE-1:0] i_lbl,
  output logic [WORD_SIZE-1:0] o_p_r,
  output logic [WORD_SIZE-1:0] o_p_g,
  output logic [WORD_SIZE-1:0] o_p_b
);

  localparam logic [WORD_SIZE-1:0] MUL_R = 8'd37;
  localparam logic [WORD_SIZE-1:0] MUL_G = 8'd101;
  localparam logic [WORD_SIZE-1:0] MUL_B = 8'd173;

  // Context width is WORD_SIZE, so the product wraps mod 2^WORD_SIZE.
  assign o_p_r = i_lbl * MUL_R;
  assign o_p_g = i_lbl * MUL_G;
  assign o_p_b = i_lbl * MUL_B;

endmodule

// File: rtl/lbl2rgb.sv
// lbl2rgb
// Streaming label/intensity to RGB converter. Two-stage pipeline with a
// valid/ready handshake on both sides and full backpressure. Also tracks the
// largest label per frame for host readout.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_lbl                label (hash/binary modes) or intensity in low byte
//   in_mode               0 hash, 1 grey, 2 binary mask, 3 same as 0
//   in_eof                last pixel of a frame
//   out_valid/out_ready   output handshake
//   out_r/out_g/out_b     colour channels
//   out_eof               in_eof travelling with its pixel
//   frame_max_lbl         max label of the last completed frame
//   frame_done            one-cycle pulse when frame_max_lbl updates
module lbl2rgb
  import lbl2rgb_pkg::*;
#(
  parameter int                   LBL_WIDTH = DEF_LBL_WIDTH,
  parameter logic [WORD_SIZE-1:0] FLOOR     = 8'h40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LBL_WIDTH-1:0] in_lbl,
  input  logic [1:0]           in_mode,
  input  logic                 in_eof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_r,
  output logic [WORD_SIZE-1:0] out_g,
  output logic [WORD_SIZE-1:0] out_b,
  output logic                 out_eof,
  output logic [LBL_WIDTH-1:0] frame_max_lbl,
  output logic                 frame_done
);

  // Final colour selection for one pixel; packed as {R, G, B}.
  function automatic logic [3*WORD_SIZE-1:0] sel_rgb(
    input mode_t                 mode,
    input logic [LBL_WIDTH-1:0]  lbl,
    input logic [WORD_SIZE-1:0]  pr,
    input logic [WORD_SIZE-1:0]  pg,
    input logic [WORD_SIZE-1:0]  pb
  );
    logic                 nz;
    logic [WORD_SIZE-1:0] g;
    nz = |lbl;
    g  = lbl[WORD_SIZE-1:0];
    case (mode)
      MODE_GREY: sel_rgb = {g, g, g};
      MODE_BIN:  sel_rgb = nz ? {MAX, MAX, MAX} : {MIN, MIN, MIN};
      // Background stays black; everything else gets FLOOR so it is never
      // near-black on screen.
      default:   sel_rgb = nz ? {pr | FLOOR, pg | FLOOR, pb | FLOOR} : '0;
    endcase
  endfunction

  logic                 w_s1_load;
  logic                 w_s2_load;
  logic                 w_acc;
  logic [LBL_WIDTH-1:0] w_new_max;
  logic [WORD_SIZE-1:0] w_p_r;
  logic [WORD_SIZE-1:0] w_p_g;
  logic [WORD_SIZE-1:0] w_p_b;

  logic                 r_vld_p1;
  logic [LBL_WIDTH-1:0] r_lbl_p1;
  mode_t                r_mode_p1;
  logic                 r_eof_p1;
  logic [WORD_SIZE-1:0] r_pr_p1;
  logic [WORD_SIZE-1:0] r_pg_p1;
  logic [WORD_SIZE-1:0] r_pb_p1;

  logic                 r_vld_p2;
  logic [WORD_SIZE-1:0] r_r_p2;
  logic [WORD_SIZE-1:0] r_g_p2;
  logic [WORD_SIZE-1:0] r_b_p2;
  logic                 r_eof_p2;

  logic [LBL_WIDTH-1:0] r_run_max;
  logic [LBL_WIDTH-1:0] r_frame_max;
  logic                 r_frame_done;

  // S2 drains whenever its current pixel leaves (or it is empty); S1 may
  // refill in the same cycle it hands off, so the pipe never bubbles.
  assign w_s2_load = r_vld_p1 && (!r_vld_p2 || out_ready);
  assign in_ready  = !r_vld_p1 || w_s2_load;
  assign w_s1_load = in_valid && in_ready;
  assign w_acc     = w_s1_load;
  assign w_new_max = (in_lbl > r_run_max) ? in_lbl : r_run_max;

  lbl2rgb_hash u_hash (
    .i_lbl (in_lbl[WORD_SIZE-1:0]),
    .o_p_r (w_p_r),
    .o_p_g (w_p_g),
    .o_p_b (w_p_b)
  );

  // ---- Stage 1: label, mode, eof and hash products ----
  always_ff @(posedge clk) begin
    if (w_s1_load) begin
      r_lbl_p1  <= in_lbl;
      r_mode_p1 <= mode_t'(in_mode);
      r_eof_p1  <= in_eof;
      r_pr_p1   <= w_p_r;
      r_pg_p1   <= w_p_g;
      r_pb_p1   <= w_p_b;
    end
  end

  // ---- Stage 2: final RGB; control, output regs and frame tracking ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1     <= 1'b0;
      r_vld_p2     <= 1'b0;
      r_r_p2       <= '0;
      r_g_p2       <= '0;
      r_b_p2       <= '0;
      r_eof_p2     <= 1'b0;
      r_run_max    <= '0;
      r_frame_max  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_s1_load)      r_vld_p1 <= 1'b1;
      else if (w_s2_load) r_vld_p1 <= 1'b0;

      if (w_s2_load)      r_vld_p2 <= 1'b1;
      else if (out_ready) r_vld_p2 <= 1'b0;

      if (w_s2_load) begin
        {r_r_p2, r_g_p2, r_b_p2} <= sel_rgb(r_mode_p1, r_lbl_p1,
                                            r_pr_p1, r_pg_p1, r_pb_p1);
        r_eof_p2 <= r_eof_p1;
      end

      // Frame max is published at acceptance of the eof pixel, without
      // waiting for that pixel to leave the pipeline.
      r_frame_done <= 1'b0;
      if (w_acc) begin
        if (in_eof) begin
          r_frame_max  <= w_new_max;
          r_frame_done <= 1'b1;
          r_run_max    <= '0;
        end else begin
          r_run_max    <= w_new_max;
        end
      end
    end
  end

  assign out_valid     = r_vld_p2;
  assign out_r         = r_r_p2;
  assign out_g         = r_g_p2;
  assign out_b         = r_b_p2;
  assign out_eof       = r_eof_p2;
  assign frame_max_lbl = r_frame_max;
  assign frame_done    = r_frame_done;

endmodule
